// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and mode codes for the memory port arbiter.
// The arbiter replaces the fixed layer_type mux in front of the data loaders.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Fixed mode grants the client named by sel (the layer_type code); RR rotates.
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_fsm.sv
// One arbitration direction: IDLE/LOCK state, registered grant, rr pointer,
// burst counter and release logic. Instantiated once for writes, once for reads.
module mem_port_arbiter_fsm
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_CLIENT  = 4,
    parameter int SELW      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    input  logic [N_CLIENT-1:0] req,
    input  logic                mem_ready,
    input  logic                block,
    output logic                locked,
    output logic [SELW-1:0]     gnt,
    output logic                m_valid,
    output logic                beat
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    arb_state_t          state_reg;
    logic [SELW-1:0]     gnt_reg;
    logic [SELW-1:0]     rr_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic                mode_reg;

    logic [2**SELW-1:0]  req_ext;
    logic                pick_found;
    logic [SELW-1:0]     pick_gnt;
    logic [SELW-1:0]     cand;
    logic                release_now;

    // Pad requests to the full select range so out-of-range selects read as idle.
    always_comb begin
        req_ext = '0;
        req_ext[N_CLIENT-1:0] = req;
    end

    // Descending scan: the last hit written is the nearest requester at/after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_gnt   = sel;
        cand       = '0;
        if (mode == ARB_FIXED) begin
            pick_found = req_ext[sel];
        end else begin
            for (int k = N_CLIENT - 1; k >= 0; k--) begin
                cand = SELW'((int'(rr_ptr_reg) + k) % N_CLIENT);
                if (req_ext[cand]) begin
                    pick_found = 1'b1;
                    pick_gnt   = cand;
                end
            end
        end
    end

    assign locked  = (state_reg == ST_LOCK);
    assign gnt     = gnt_reg;
    assign m_valid = locked && req_ext[gnt_reg] && !block;
    assign beat    = m_valid && mem_ready;

    // A beat in the release cycle still completes; the state change lands at the edge.
    assign release_now = locked &&
                         (!req_ext[gnt_reg] ||
                          (beat && (count_reg == CW'(MAX_BURST - 1))) ||
                          ((mode == ARB_FIXED) && (sel != gnt_reg)) ||
                          (mode != mode_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            rr_ptr_reg <= '0;
            count_reg  <= '0;
            mode_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_reg <= ST_LOCK;
                        gnt_reg   <= pick_gnt;
                        mode_reg  <= mode;
                        count_reg <= '0;
                    end
                end
                ST_LOCK: begin
                    if (release_now) begin
                        state_reg  <= ST_IDLE;
                        rr_ptr_reg <= SELW'((int'(gnt_reg) + 1) % N_CLIENT);
                        count_reg  <= '0;
                    end else if (beat) begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-client arbiter for the external memory read/write interface, with an
// in-order read ID tracker that routes returning data to the issuing client.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_CLIENT  = 4,
    parameter int SELW      = 2,
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16,
    parameter int RD_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic [N_CLIENT-1:0]    c_wvalid,
    output logic [N_CLIENT-1:0]    c_wready,
    input  logic [N_CLIENT*AW-1:0] c_waddr,
    input  logic [N_CLIENT*DW-1:0] c_wdata,
    input  logic [N_CLIENT-1:0]    c_rvalid,
    output logic [N_CLIENT-1:0]    c_rack,
    input  logic [N_CLIENT*AW-1:0] c_raddr,
    output logic [N_CLIENT-1:0]    c_rready,
    output logic [N_CLIENT*DW-1:0] c_rdata,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic [AW-1:0]          m_waddr,
    output logic [DW-1:0]          m_wdata,
    output logic                   m_rvalid,
    input  logic                   m_rack,
    output logic [AW-1:0]          m_raddr,
    input  logic                   m_rready,
    input  logic [DW-1:0]          m_rdata,
    output logic                   busy,
    output logic                   rd_err
);

    localparam int PW = $clog2(RD_DEPTH) + 1;

    logic            w_locked, r_locked;
    logic [SELW-1:0] w_gnt, r_gnt;
    logic            w_beat, r_beat;

    logic [AW-1:0]   waddr_arr [N_CLIENT];
    logic [DW-1:0]   wdata_arr [N_CLIENT];
    logic [AW-1:0]   raddr_arr [N_CLIENT];

    logic [SELW-1:0] id_mem [RD_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic            fifo_empty, fifo_full, pop;
    logic [SELW-1:0] head_id;

    mem_port_arbiter_fsm #(
        .N_CLIENT (N_CLIENT),
        .SELW     (SELW),
        .MAX_BURST(MAX_BURST)
    ) u_wr_fsm (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .req      (c_wvalid),
        .mem_ready(m_wready),
        .block    (1'b0),
        .locked   (w_locked),
        .gnt      (w_gnt),
        .m_valid  (m_wvalid),
        .beat     (w_beat)
    );

    // Reads may not issue while every tracker slot is in use.
    mem_port_arbiter_fsm #(
        .N_CLIENT (N_CLIENT),
        .SELW     (SELW),
        .MAX_BURST(MAX_BURST)
    ) u_rd_fsm (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .req      (c_rvalid),
        .mem_ready(m_rack),
        .block    (fifo_full),
        .locked   (r_locked),
        .gnt      (r_gnt),
        .m_valid  (m_rvalid),
        .beat     (r_beat)
    );

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                        (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
    assign pop        = m_rready && !fifo_empty;
    assign head_id    = id_mem[rd_ptr_reg[PW-2:0]];

    generate
        for (genvar gi = 0; gi < N_CLIENT; gi++) begin : g_client
            assign waddr_arr[gi] = c_waddr[gi*AW +: AW];
            assign wdata_arr[gi] = c_wdata[gi*DW +: DW];
            assign raddr_arr[gi] = c_raddr[gi*AW +: AW];

            assign c_wready[gi] = w_beat && (w_gnt == SELW'(gi));
            assign c_rack[gi]   = r_beat && (r_gnt == SELW'(gi));
            assign c_rready[gi] = pop && (head_id == SELW'(gi));
            assign c_rdata[gi*DW +: DW] = c_rready[gi] ? m_rdata : '0;
        end
    endgenerate

    // Payload is gated while idle so the memory side sees zeros between grants.
    assign m_waddr = w_locked ? waddr_arr[w_gnt] : '0;
    assign m_wdata = w_locked ? wdata_arr[w_gnt] : '0;
    assign m_raddr = r_locked ? raddr_arr[r_gnt] : '0;

    assign busy = w_locked || r_locked || !fifo_empty;

    always_ff @(posedge clk) begin
        if (r_beat) begin
            id_mem[wr_ptr_reg[PW-2:0]] <= r_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rd_err     <= 1'b0;
        end else begin
            if (r_beat) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (m_rready && fifo_empty) begin
                rd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked by a transaction-level
// scoreboard (who may be acknowledged, which client each return belongs to).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int SELW = 2;
    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int MB   = 3;
    localparam int RD   = 4;
    localparam int RAND_CYCLES = 800;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [N-1:0]    c_wvalid, c_wready, c_rvalid, c_rack, c_rready;
    logic [N*AW-1:0] c_waddr, c_raddr;
    logic [N*DW-1:0] c_wdata, c_rdata;
    logic            m_wvalid, m_wready, m_rvalid, m_rack, m_rready;
    logic [AW-1:0]   m_waddr, m_raddr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic            busy, rd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .N_CLIENT(N), .SELW(SELW), .AW(AW), .DW(DW), .MAX_BURST(MB), .RD_DEPTH(RD)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .c_wvalid(c_wvalid), .c_wready(c_wready), .c_waddr(c_waddr), .c_wdata(c_wdata),
        .c_rvalid(c_rvalid), .c_rack(c_rack), .c_raddr(c_raddr),
        .c_rready(c_rready), .c_rdata(c_rdata),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_rvalid(m_rvalid), .m_rack(m_rack), .m_raddr(m_raddr),
        .m_rready(m_rready), .m_rdata(m_rdata),
        .busy(busy), .rd_err(rd_err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } ret_t;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] oh(input int i);
        return 128'(1) << i;
    endfunction

    function automatic logic [127:0] rvec(input int i, input logic [31:0] d);
        return 128'(d) << (i * DW);
    endfunction

    function automatic logic [127:0] waddr_of(input int i);
        return 128'(c_waddr[i*AW +: AW]);
    endfunction

    function automatic logic [127:0] wdata_of(input int i);
        return 128'(c_wdata[i*DW +: DW]);
    endfunction

    function automatic logic [127:0] raddr_of(input int i);
        return 128'(c_raddr[i*AW +: AW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fixed_payload();
        for (int i = 0; i < N; i++) begin
            c_waddr[i*AW +: AW] = AW'(32'h1000 + i * 16);
            c_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
            c_raddr[i*AW +: AW] = AW'(32'h2000 + i * 16);
        end
    endtask

    task automatic do_reset(input logic m);
        rst = 1'b1; mode = m; sel = '0;
        c_wvalid = '0; c_rvalid = '0;
        m_wready = 1'b0; m_rack = 1'b0; m_rready = 1'b0; m_rdata = '0;
        fixed_payload();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_wvalid"}, 128'(m_wvalid), '0);
        chk({tag, "_m_rvalid"}, 128'(m_rvalid), '0);
        chk({tag, "_c_wready"}, 128'(c_wready), '0);
        chk({tag, "_c_rack"},   128'(c_rack),   '0);
        chk({tag, "_c_rready"}, 128'(c_rready), '0);
        chk({tag, "_c_rdata"},  128'(c_rdata),  '0);
        chk({tag, "_m_waddr"},  128'(m_waddr),  '0);
        chk({tag, "_m_wdata"},  128'(m_wdata),  '0);
        chk({tag, "_m_raddr"},  128'(m_raddr),  '0);
        chk({tag, "_busy"},     128'(busy),     '0);
        chk({tag, "_rd_err"},   128'(rd_err),   '0);
    endtask

    // One idle arbitration cycle, n accepted reads, then the drop-valid cycle.
    task automatic issue(input int cl, input int n);
        c_rvalid = N'(oh(cl));
        settle();
        chk($sformatf("issue_c%0d_idle_rack", cl), 128'(c_rack), '0);
        tick();
        for (int j = 0; j < n; j++) begin
            settle();
            chk($sformatf("issue_c%0d_rack%0d", cl, j), 128'(c_rack), oh(cl));
            chk($sformatf("issue_c%0d_raddr%0d", cl, j), 128'(m_raddr), raddr_of(cl));
            tick();
        end
        c_rvalid = '0;
        settle();
        chk($sformatf("issue_c%0d_drop_rack", cl), 128'(c_rack), '0);
        tick();
    endtask

    task automatic ret(input int cl, input logic [31:0] d);
        m_rready = 1'b1;
        m_rdata  = d;
        settle();
        chk($sformatf("ret_c%0d_rready", cl), 128'(c_rready), oh(cl));
        chk($sformatf("ret_c%0d_rdata", cl), 128'(c_rdata), rvec(cl, d));
        tick();
        m_rready = 1'b0;
        m_rdata  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ret_t        mem_q[$];
        int          exp_q[$];
        int          out_before;
        int          cl;
        int          p;
        bit          draining;
        logic [31:0] ret_d;

        // Reset state
        do_reset(ARB_FIXED);
        settle();
        chk_quiet("reset");
        tick();

        // 1: fixed mode, sel=1, single writer
        sel = 2'd1; c_wvalid = 4'b0010; m_wready = 1'b0;
        settle();
        chk("t1_idle_wready", 128'(c_wready), '0);
        chk("t1_idle_mwvalid", 128'(m_wvalid), '0);
        tick();
        m_wready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            settle();
            chk($sformatf("t1_wready%0d", b), 128'(c_wready), oh(1));
            chk($sformatf("t1_waddr%0d", b), 128'(m_waddr), waddr_of(1));
            chk($sformatf("t1_wdata%0d", b), 128'(m_wdata), wdata_of(1));
            tick();
        end
        c_wvalid = '0; m_wready = 1'b0;
        settle();
        chk("t1_after_busy", 128'(busy), '0);

        // 2: round-robin, everyone writing, bursts of MB beats, one idle cycle between
        do_reset(ARB_RR);
        c_wvalid = 4'hF; m_wready = 1'b1;
        for (int k = 0; k < N * (MB + 1) + 2; k++) begin
            settle();
            p = k % (MB + 1);
            cl = (k / (MB + 1)) % N;
            if (p == 0) begin
                chk($sformatf("t2_idle_k%0d", k), 128'(c_wready), '0);
            end else begin
                chk($sformatf("t2_wready_k%0d", k), 128'(c_wready), oh(cl));
                chk($sformatf("t2_waddr_k%0d", k), 128'(m_waddr), waddr_of(cl));
            end
            tick();
        end
        c_wvalid = '0; m_wready = 1'b0;
        tick();

        // 3: c0 then c2 each issue two reads; returns routed in order
        do_reset(ARB_RR);
        m_rack = 1'b1;
        issue(0, 2);
        issue(2, 2);
        m_rack = 1'b0;
        tick(); tick();
        settle();
        chk("t3_busy_outstanding", 128'(busy), 128'(1));
        ret(0, 32'h1111_0000);
        ret(0, 32'h1111_0001);
        ret(2, 32'h2222_0000);
        ret(2, 32'h2222_0001);
        settle();
        chk("t3_busy_drained", 128'(busy), '0);

        // 4: tracker full blocks the request until the cycle after the first return
        do_reset(ARB_RR);
        m_rack = 1'b1; c_rvalid = 4'b0010;
        settle();
        chk("t4_idle_mrvalid", 128'(m_rvalid), '0);
        tick();
        for (int b = 0; b < MB; b++) begin
            settle();
            chk($sformatf("t4_rack%0d", b), 128'(c_rack), oh(1));
            tick();
        end
        settle();
        chk("t4_rearb_rack", 128'(c_rack), '0);
        tick();
        settle();
        chk("t4_fourth_rack", 128'(c_rack), oh(1));
        tick();
        for (int b = 0; b < 2; b++) begin
            settle();
            chk($sformatf("t4_full_mrvalid%0d", b), 128'(m_rvalid), '0);
            chk($sformatf("t4_full_rack%0d", b), 128'(c_rack), '0);
            tick();
        end
        m_rready = 1'b1; m_rdata = 32'h4444_0000;
        settle();
        chk("t4_pop_no_bypass", 128'(m_rvalid), '0);
        chk("t4_pop_rready", 128'(c_rready), oh(1));
        tick();
        m_rready = 1'b0; m_rdata = '0;
        settle();
        chk("t4_unblocked_mrvalid", 128'(m_rvalid), 128'(1));
        chk("t4_unblocked_rack", 128'(c_rack), oh(1));
        tick();
        c_rvalid = '0; m_rack = 1'b0;
        tick();
        for (int b = 0; b < RD; b++) begin
            ret(1, 32'h4444_0001 + 32'(b));
        end
        settle();
        chk("t4_drained_busy", 128'(busy), '0);
        chk("t4_rd_err_clear", 128'(rd_err), '0);

        // 5: return with nothing outstanding
        m_rready = 1'b1; m_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t5_no_rready", 128'(c_rready), '0);
        chk("t5_no_rdata", 128'(c_rdata), '0);
        tick();
        m_rready = 1'b0; m_rdata = '0;
        for (int b = 0; b < 3; b++) begin
            settle();
            chk($sformatf("t5_rd_err_held%0d", b), 128'(rd_err), 128'(1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_rd_err_reset", 128'(rd_err), '0);

        // 6: reset mid-burst with two reads outstanding
        do_reset(ARB_RR);
        c_rvalid = 4'b1000; c_wvalid = 4'b0001; m_rack = 1'b1; m_wready = 1'b1;
        tick();
        for (int b = 0; b < 2; b++) begin
            settle();
            chk($sformatf("t6_rack%0d", b), 128'(c_rack), oh(3));
            chk($sformatf("t6_wready%0d", b), 128'(c_wready), oh(0));
            tick();
        end
        c_rvalid = '0; m_wready = 1'b0;
        settle();
        chk("t6_busy_before_rst", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk_quiet("t6_after_rst");
        c_wvalid = '0; m_rack = 1'b0;
        tick();
        m_rready = 1'b1; m_rdata = 32'h6666_0000;
        settle();
        chk("t6_late_no_rready", 128'(c_rready), '0);
        tick();
        m_rready = 1'b0; m_rdata = '0;
        settle();
        chk("t6_late_rd_err", 128'(rd_err), 128'(1));

        // Randomized run against the scoreboard
        do_reset(ARB_RR);
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            draining = (cyc >= RAND_CYCLES - 60);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0) sel = SELW'($urandom_range(0, N - 1));
            if (draining) begin
                c_wvalid = '0;
                c_rvalid = '0;
            end else begin
                if ($urandom_range(0, 3) == 0) c_wvalid = N'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) c_rvalid = N'($urandom_range(0, 15));
            end
            for (int i = 0; i < N; i++) begin
                c_waddr[i*AW +: AW] = AW'($urandom);
                c_wdata[i*DW +: DW] = $urandom;
                c_raddr[i*AW +: AW] = AW'($urandom);
            end
            m_wready = ($urandom_range(0, 3) != 0);
            m_rack   = ($urandom_range(0, 3) != 0);
            m_rready = 1'b0;
            m_rdata  = $urandom;
            ret_d    = '0;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                (draining || $urandom_range(0, 3) != 0)) begin
                m_rready = 1'b1;
                ret_d    = mem_q[0].data;
                m_rdata  = ret_d;
                void'(mem_q.pop_front());
            end
            settle();
            out_before = exp_q.size();

            if (m_wvalid && m_wready) begin
                chk("rnd_wready_onehot", 128'($countones(c_wready)), 128'(1));
                for (int i = 0; i < N; i++) begin
                    if (c_wready[i]) begin
                        chk("rnd_wready_req", 128'(c_wvalid[i]), 128'(1));
                        chk("rnd_waddr", 128'(m_waddr), waddr_of(i));
                        chk("rnd_wdata", 128'(m_wdata), wdata_of(i));
                    end
                end
            end else begin
                chk("rnd_wready_zero", 128'(c_wready), '0);
            end

            if (out_before == RD) begin
                chk("rnd_full_block", 128'(m_rvalid), '0);
            end

            if (m_rready) begin
                cl = exp_q.pop_front();
                chk("rnd_rready_route", 128'(c_rready), oh(cl));
                chk("rnd_rdata_route", 128'(c_rdata), rvec(cl, ret_d));
            end else begin
                chk("rnd_rready_zero", 128'(c_rready), '0);
                chk("rnd_rdata_zero", 128'(c_rdata), '0);
            end

            if (m_rvalid && m_rack) begin
                chk("rnd_rack_onehot", 128'($countones(c_rack)), 128'(1));
                for (int i = 0; i < N; i++) begin
                    if (c_rack[i]) begin
                        chk("rnd_rack_req", 128'(c_rvalid[i]), 128'(1));
                        chk("rnd_raddr", 128'(m_raddr), raddr_of(i));
                        exp_q.push_back(i);
                        mem_q.push_back('{data: $urandom, due: cyc + 1 + int'($urandom_range(0, 3))});
                    end
                end
            end else begin
                chk("rnd_rack_zero", 128'(c_rack), '0);
            end

            if (out_before > 0 || m_wvalid || m_rvalid) begin
                chk("rnd_busy", 128'(busy), 128'(1));
            end
            chk("rnd_rd_err", 128'(rd_err), '0);
            tick();
        end
        settle();
        chk("rnd_final_outstanding", 128'(exp_q.size()), '0);
        chk("rnd_final_busy", 128'(busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
